// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and the command record for the ALU command driver.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;
   localparam logic [2:0] OP_SLT = 3'd4;
   localparam logic [2:0] OP_ADD = 3'd5;
   localparam logic [2:0] OP_SUB = 3'd6;
   localparam logic [2:0] OP_MOD = 3'd7;

   localparam logic [31:0] MOD_ERR_RESULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MRST = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } drv_state_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        cin;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, registered head, count-based full/empty.
// Caller gates push with !full and pop with !empty; simultaneous push/pop keeps the count.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 68
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      mem_q <= mem_d;
   end

   assign pop_dat = mem_q[rd_ptr_q];
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives the ALU pins, waits the op settle time and holds the result
// in a response register; cmd_ready drops when the FIFO is full, the response holds until rsp_ready.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MOD_WAIT = 64
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_cout,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic [31:0] alu_ain,
   output logic [31:0] alu_bin,
   output logic [2:0]  alu_op,
   output logic        alu_cin,
   output logic        alu_reset,
   input  logic [31:0] alu_result,
   input  logic        alu_cout,
   output logic        busy
);

   localparam int CNT_W = $clog2(MOD_WAIT) + 1;

   drv_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_cout_q, rsp_cout_d;
   logic [2:0]  rsp_op_q, rsp_op_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] alu_ain_q, alu_ain_d;
   logic [31:0] alu_bin_q, alu_bin_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic        alu_cin_q, alu_cin_d;

   alu_cmd_t    cmd_in;
   alu_cmd_t    cmd_head;
   logic        fifo_full, fifo_empty, fifo_push, fifo_pop;

   assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, cin: cmd_cin};
   assign cmd_ready = reset && !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(alu_cmd_t))
   ) u_fifo (
      .CLK      (CLK),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (cmd_in),
      .pop      (fifo_pop),
      .pop_dat  (cmd_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_cout_d   = rsp_cout_q;
      rsp_op_d     = rsp_op_q;
      rsp_err_d    = rsp_err_q;
      alu_ain_d    = alu_ain_q;
      alu_bin_d    = alu_bin_q;
      alu_op_d     = alu_op_q;
      alu_cin_d    = alu_cin_q;
      fifo_pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               alu_ain_d = cmd_head.a;
               alu_bin_d = cmd_head.b;
               alu_op_d  = cmd_head.op;
               alu_cin_d = cmd_head.cin;
               rsp_op_d  = cmd_head.op;
               if (cmd_head.op != OP_MOD) begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end else if (cmd_head.b != '0) begin
                  state_d = MRST;
               end else begin
                  // Divide by zero never reaches the ALU; answer straight away.
                  state_d      = RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_err_d    = 1'b1;
                  rsp_result_d = MOD_ERR_RESULT;
                  rsp_cout_d   = 1'b0;
               end
            end
         end
         MRST: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(MOD_WAIT - 1);
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b0;
               rsp_result_d = alu_result;
               rsp_cout_d   = alu_cout;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_op_q     <= '0;
         rsp_err_q    <= 1'b0;
         alu_ain_q    <= '0;
         alu_bin_q    <= '0;
         alu_op_q     <= '0;
         alu_cin_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_cout_q   <= rsp_cout_d;
         rsp_op_q     <= rsp_op_d;
         rsp_err_q    <= rsp_err_d;
         alu_ain_q    <= alu_ain_d;
         alu_bin_q    <= alu_bin_d;
         alu_op_q     <= alu_op_d;
         alu_cin_q    <= alu_cin_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_cout   = rsp_cout_q;
   assign rsp_op     = rsp_op_q;
   assign rsp_err    = rsp_err_q;
   assign alu_ain    = alu_ain_q;
   assign alu_bin    = alu_bin_q;
   assign alu_op     = alu_op_q;
   assign alu_cin    = alu_cin_q;
   // The ALU is held in reset alongside the driver so it restarts from a clean state.
   assign alu_reset  = !reset || (state_q == MRST);
   assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural 32-bit ALU attached.
module tb_alu_cmd_driver;

   localparam int DEPTH    = 4;
   localparam int MOD_WAIT = 8;

   logic        CLK = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic        cmd_cin;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_cout;
   logic [2:0]  rsp_op;
   logic        rsp_err;
   logic [31:0] alu_ain, alu_bin;
   logic [2:0]  alu_op;
   logic        alu_cin, alu_reset;
   logic [31:0] alu_result;
   logic        alu_cout;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int pulse_cnt = 0;

   always #5 CLK = ~CLK;

   alu_cmd_driver #(.DEPTH(DEPTH), .MOD_WAIT(MOD_WAIT)) dut (
      .CLK(CLK), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_reset(alu_reset), .alu_result(alu_result), .alu_cout(alu_cout),
      .busy(busy)
   );

   // Behavioural ALU: MOD only yields a%b a few cycles after an alu_reset pulse.
   logic [31:0] mod_res = '0;
   logic [2:0]  mod_cd = '0;
   always @(posedge CLK) begin
      if (alu_reset) begin
         mod_res <= '0;
         mod_cd  <= 3'd4;
      end else if (mod_cd != 0) begin
         mod_cd <= mod_cd - 3'd1;
         if (mod_cd == 3'd1) mod_res <= (alu_bin == 0) ? 32'd0 : alu_ain % alu_bin;
      end
      if (reset && alu_reset) pulse_cnt <= pulse_cnt + 1;
   end

   always_comb begin
      alu_result = '0;
      alu_cout   = 1'b0;
      case (alu_op)
         3'd0: alu_result = alu_ain & alu_bin;
         3'd1: alu_result = alu_ain | alu_bin;
         3'd2: alu_result = alu_ain ^ alu_bin;
         3'd3: alu_result = ~(alu_ain | alu_bin);
         3'd4: alu_result = ($signed(alu_ain) < $signed(alu_bin)) ? 32'd1 : 32'd0;
         3'd5: {alu_cout, alu_result} = {1'b0, alu_ain} + {1'b0, alu_bin} + {32'd0, alu_cin};
         3'd6: {alu_cout, alu_result} = {1'b0, alu_ain} + {1'b0, ~alu_bin} + 33'd1;
         default: alu_result = mod_res;
      endcase
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic cin);
      int n;
      n = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin; cmd_valid = 1'b1;
      while (!cmd_ready && n < 300) begin
         tick();
         n++;
      end
      check("send_rdy", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge; latency counted in edges.
   task automatic expect_rsp(input string tag, input logic [31:0] e_res, input logic e_cout,
                             input logic [2:0] e_op, input logic e_err, input int e_lat);
      int n;
      n = 0;
      while (!rsp_valid && n < 300) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(e_lat));
      check({tag, "_res"}, rsp_result, e_res);
      check({tag, "_cout"}, {31'd0, rsp_cout}, {31'd0, e_cout});
      check({tag, "_op"}, {29'd0, rsp_op}, {29'd0, e_op});
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e_err});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   logic [31:0] bp_a   [6] = '{32'hF0F0_F0F0, 32'h0F, 32'hFF, 32'h0, 32'hFFFF_FFFF, 32'd3};
   logic [31:0] bp_b   [6] = '{32'hFF00_FF00, 32'hF0, 32'h0F, 32'h0, 32'h1, 32'd4};
   logic [2:0]  bp_op  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
   logic [31:0] bp_res [5] = '{32'hF000_F000, 32'hFF, 32'hF0, 32'hFFFF_FFFF, 32'h1};

   initial begin
      int acc, idx, k, stale;
      logic took;

      reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_cin = 1'b0;
      repeat (3) tick();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_alu_reset", {31'd0, alu_reset}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu_ain", alu_ain, 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      reset = 1'b1;
      #1;
      check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rel_alu_reset", {31'd0, alu_reset}, 32'd0);

      // AND with step-by-step latency
      send(32'd5, 32'd7, 3'd0, 1'b0);
      check("and_t0_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("and_t1_ain", alu_ain, 32'd5);
      check("and_t1_bin", alu_bin, 32'd7);
      check("and_t1_valid", {31'd0, rsp_valid}, 32'd0);
      expect_rsp("and", 32'd5, 1'b0, 3'd0, 1'b0, 1);

      send(32'd5, 32'd7, 3'd3, 1'b0);
      expect_rsp("nor", 32'hFFFF_FFF8, 1'b0, 3'd3, 1'b0, 2);
      send(32'd10, 32'd6, 3'd5, 1'b0);
      expect_rsp("add", 32'd16, 1'b0, 3'd5, 1'b0, 2);
      send(32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
      expect_rsp("add_wrap", 32'd0, 1'b1, 3'd5, 1'b0, 2);

      // Modulo with reset pulse, then divide by zero
      pulse_cnt = 0;
      send(32'd47, 32'd3, 3'd7, 1'b0);
      tick(); tick(); tick();
      check("mod_hold_bin", alu_bin, 32'd3);
      check("mod_hold_op", {29'd0, alu_op}, 32'd7);
      expect_rsp("mod", 32'd2, 1'b0, 3'd7, 1'b0, 2 + MOD_WAIT - 3);
      check("mod_pulses", 32'(pulse_cnt), 32'd1);
      pulse_cnt = 0;
      send(32'd47, 32'd0, 3'd7, 1'b0);
      expect_rsp("mod0", 32'hFFFF_FFFF, 1'b0, 3'd7, 1'b1, 1);
      check("mod0_pulses", 32'(pulse_cnt), 32'd0);

      // Backpressure: 6 offered with rsp_ready low
      acc = 0; idx = 0;
      cmd_a = bp_a[0]; cmd_b = bp_b[0]; cmd_op = bp_op[0]; cmd_cin = 1'b0;
      cmd_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         took = cmd_ready;
         tick();
         if (took) begin
            acc++;
            if (idx < 5) begin
               idx++;
               cmd_a = bp_a[idx]; cmd_b = bp_b[idx]; cmd_op = bp_op[idx];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      check("bp_accepted", 32'(acc), 32'd5);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      repeat (4) tick();
      check("bp_hold_res", rsp_result, bp_res[0]);
      check("bp_hold_op", {29'd0, rsp_op}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 60 && k < 5; c++) begin
         if (rsp_valid) begin
            check("bp_drain_op", {29'd0, rsp_op}, {29'd0, bp_op[k]});
            check("bp_drain_res", rsp_result, bp_res[k]);
            k++;
         end
         tick();
      end
      rsp_ready = 1'b0;
      check("bp_drained", 32'(k), 32'd5);
      check("bp_idle", {31'd0, busy}, 32'd0);

      // Reset during MOD WAIT with two commands queued
      send(32'd100, 32'd7, 3'd7, 1'b0);
      send(32'd1, 32'd2, 3'd5, 1'b0);
      send(32'd3, 32'd4, 3'd5, 1'b0);
      check("mrst_pre_busy", {31'd0, busy}, 32'd1);
      check("mrst_pre_alu_reset", {31'd0, alu_reset}, 32'd0);
      reset = 1'b0;
      #1;
      check("mrst_alu_reset", {31'd0, alu_reset}, 32'd1);
      check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mrst_rsp_op", {29'd0, rsp_op}, 32'd0);
      check("mrst_alu_ain", alu_ain, 32'd0);
      check("mrst_alu_bin", alu_bin, 32'd0);
      check("mrst_alu_op", {29'd0, alu_op}, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      stale = 0;
      repeat (15) begin
         tick();
         if (rsp_valid) stale++;
      end
      check("mrst_no_stale", 32'(stale), 32'd0);
      check("mrst_post_busy", {31'd0, busy}, 32'd0);
      send(32'd9, 32'd4, 3'd6, 1'b0);
      expect_rsp("sub", 32'd5, 1'b1, 3'd6, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Initiator-side companion to the 32-bit ALU: accepts operation commands over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU operand, opcode, carry and reset pins. It waits the op-dependent settle time, including the multi-cycle MOD sequence with its ALU reset pulse. It then captures result/carry into a response register held under a valid/ready handshake. It sits between any command source (sequencer, bench, control FSM) and the `alu` instance.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `MOD_WAIT`, 64: cycles the ALU is given to finish MOD after its reset pulse (≥1)
- `CLK  in  1`: sole clock, rising edge
- `reset  in  1`: synchronous, active-low reset
- `cmd_valid  in  1` / `cmd_ready  out  1`: command handshake; transfer on the edge where both are high
- `cmd_a  in  32`, `cmd_b  in  32`, `cmd_op  in  3`, `cmd_cin  in  1`: command payload
- `rsp_valid  out  1` / `rsp_ready  in  1`: response handshake
- `rsp_result  out  32`, `rsp_cout  out  1`, `rsp_op  out  3`, `rsp_err  out  1`: response payload
- `alu_ain  out  32`, `alu_bin  out  32`, `alu_op  out  3`, `alu_cin  out  1`: ALU drive, registered
- `alu_reset  out  1`: ALU reset, active-high
- `alu_result  in  32`, `alu_cout  in  1`: ALU outputs
- `busy  out  1`: high when state ≠ IDLE or the FIFO is non-empty

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 SLT, 5 ADD, 6 SUB, 7 MOD. Ops 0–6 are combinational in the ALU; 7 is sequential.
- FIFO:
  - `cmd_ready` = not full.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo `DEPTH`.
  - No push is accepted while full.
- FSM states: IDLE, MRST, WAIT, RESP.
- IDLE
  - If the FIFO is non-empty: pop the head into the `alu_*` drive registers and `rsp_op`.
  - op 0–6: go to WAIT with cnt=0.
  - op 7 with b≠0: go to MRST.
  - op 7 with b==0: go to RESP with `rsp_err`=1 and `rsp_result`=32'hFFFF_FFFF, `rsp_cout`=0. The ALU is not exercised.
- MRST: `alu_reset`=1 for exactly one cycle, then go to WAIT with cnt=`MOD_WAIT`-1.
- WAIT
  - If cnt==0: capture `alu_result`/`alu_cout` into the rsp registers, set `rsp_err`=0, `rsp_valid`=1, and go to RESP.
  - Otherwise decrement cnt.
- RESP: hold the payload stable while `rsp_valid`=1 and `rsp_ready`=0. On handshake, clear `rsp_valid` and return to IDLE.
- The `alu_*` drive registers hold the last command until the next pop. The ALU inputs never change during WAIT.
- Width rules: the counter is $clog2(`MOD_WAIT`)+1 bits. The count register is $clog2(`DEPTH`)+1 bits.

## Timing
- Reset (`reset`=0 at an edge) clears:
  - FIFO count and pointers → 0;
  - state → IDLE;
  - `rsp_valid`, `rsp_result`, `rsp_cout`, `rsp_op`, `rsp_err` → 0;
  - `alu_ain`, `alu_bin`, `alu_op`, `alu_cin` → 0.
- During reset:
  - `alu_reset`=1 while `reset`=0;
  - `cmd_ready`=0.
- After reset releases: `cmd_ready`=1 from the first cycle.
- Reset mid-operation (any state) aborts immediately. The queued and in-flight commands are discarded and no response is produced.
- Latency, empty FIFO and idle, command accepted at edge t:
  - ops 0–6: ALU driven after t+1; `rsp_valid` high after edge t+2.
  - MOD: `alu_reset` high during cycle t+1..t+2; `rsp_valid` high after edge t+2+`MOD_WAIT`.
  - MOD with b=0: `rsp_valid` high after edge t+1.
- Throughput for ops 0–6 with `rsp_ready` held high: one response every 3 cycles (IDLE→WAIT→RESP).
- A response handshake and a command push on the same edge are independent. Both take effect.

## Structure
- Package `alu_pkg`: opcode localparams (`OP_AND`..`OP_MOD`), the FSM state typedef, and the `MOD_ERR_RESULT` constant 32'hFFFF_FFFF.
- Sub-module `alu_cmd_fifo`: synchronous FIFO of 68-bit entries {a,b,op,cin}, with ports push/pop/full/empty. The top holds the FSM, counter and registers.

## Test plan
- AND: a=5, b=7, op=0 → `rsp_result`=5, `rsp_valid` two edges after acceptance. NOR of the same operands → 32'hFFFF_FFF8.
- ADD: a=10, b=6, cin=0, op=5 → result 16, `rsp_cout`=0. Then a=32'hFFFF_FFFF, b=1 → result 0, cout=1.
- MOD: a=47, b=3, op=7, real `alu` attached → single `alu_reset` pulse observed, result 2 after 2+`MOD_WAIT` edges, `rsp_err`=0. With b=0 → `rsp_err`=1, result 32'hFFFF_FFFF, no `alu_reset` pulse.
- Backpressure: hold `rsp_ready`=0 and offer 6 commands → exactly 5 accepted (1 in RESP, 4 in FIFO). `cmd_ready` then stays 0 and the payload holds. Releasing `rsp_ready` drains the responses in order with the correct `rsp_op` tags.
- Reset mid-MOD: assert `reset`=0 during WAIT with 2 commands queued → all outputs at reset values next edge, `alu_reset`=1, no stale response after release. A new SUB (9−4) then returns 5.
